// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: register width, writeback select codes, load funct3 codes.
package riscv_pkg;

  localparam int XLEN = 32;

  // Writeback select: which value the WB mux sends to the register file.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  // Load size/sign codes (funct3 of the LOAD opcode).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of an
// aligned memory word, extends it, and flags accesses that straddle their size.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension; unknown funct3 passes the raw word through.
  always_comb begin
    byte_sel   = rdata[{off, 3'b000} +: 8];
    half_sel   = off[1] ? rdata[31:16] : rdata[15:0];
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      F3_LHU: begin
        data       = {16'h0, half_sel};
        misaligned = off[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (off != 2'b00);
      end
      default: begin
        data       = rdata;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures memory-stage results plus formatted load
// data, gates the register-file write, and counts retired instructions.
//
// Pipeline control: on each rising edge, flush inserts a bubble (all WB state
// cleared), otherwise stall holds every register and the counter, otherwise the
// MEM-stage values are captured. There is no ready/valid backpressure; mem_valid
// marks a real instruction and wb_valid follows it one cycle later.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic [XLEN-1:0]      mem_pc_plus_4,
  input  logic [XLEN-1:0]      mem_immediate,
  input  logic [1:0]           mem_mem_to_reg,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_reg_write,
  input  logic [2:0]           mem_funct3,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic [XLEN-1:0]      wb_alu_result,
  output logic [XLEN-1:0]      wb_mem_data,
  output logic [XLEN-1:0]      wb_pc_plus_4,
  output logic [XLEN-1:0]      wb_immediate,
  output logic [1:0]           wb_mem_to_reg,
  output logic [4:0]           wb_rd,
  output logic                 wb_reg_write,
  output logic                 wb_valid,
  output logic                 wb_misaligned,
  output logic [CNT_WIDTH-1:0] instret
);

  logic [XLEN-1:0] load_data;
  logic            load_mis;
  logic            misaligned;
  logic            reg_write_next;
  logic            retire;

  load_align u_load_align (
    .rdata      (dmem_rdata),
    .funct3     (mem_funct3),
    .off        (mem_alu_result[1:0]),
    .data       (load_data),
    .misaligned (load_mis)
  );

  // Misalignment only matters for a real instruction that actually loads.
  always_comb begin
    misaligned     = load_mis & mem_valid & (mem_mem_to_reg == WB_SEL_MEM);
    reg_write_next = mem_reg_write & mem_valid & (mem_rd != 5'd0) & ~misaligned;
    retire         = mem_valid & ~misaligned;
  end

  // WB register bank with flush > stall > capture priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_pc_plus_4  <= '0;
      wb_immediate  <= '0;
      wb_mem_to_reg <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_valid      <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (flush) begin
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_pc_plus_4  <= '0;
      wb_immediate  <= '0;
      wb_mem_to_reg <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      wb_valid      <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (!stall) begin
      wb_alu_result <= mem_alu_result;
      wb_mem_data   <= load_data;
      wb_pc_plus_4  <= mem_pc_plus_4;
      wb_immediate  <= mem_immediate;
      wb_mem_to_reg <= mem_mem_to_reg;
      wb_rd         <= mem_rd;
      wb_reg_write  <= reg_write_next;
      wb_valid      <= mem_valid;
      wb_misaligned <= misaligned;
    end
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (!flush && !stall && retire) begin
      instret <= instret + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed steps plus a randomized phase, checked
// against a behavioural model of the WB stage and retire counter.
module tb_mem_wb_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT inputs ----------------
  logic        stall, flush, mem_valid, mem_reg_write;
  logic [31:0] mem_alu_result, mem_pc_plus_4, mem_immediate, dmem_rdata;
  logic [1:0]  mem_mem_to_reg;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;

  // ---------------- DUT outputs (32-bit counter) ----------------
  logic [31:0] wb_alu_result, wb_mem_data, wb_pc_plus_4, wb_immediate;
  logic [1:0]  wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_valid, wb_misaligned;
  logic [31:0] instret;

  // ---------------- DUT outputs (4-bit counter) ----------------
  logic [31:0] n_alu_result, n_mem_data, n_pc_plus_4, n_immediate;
  logic [1:0]  n_mem_to_reg;
  logic [4:0]  n_rd;
  logic        n_reg_write, n_valid, n_misaligned;
  logic [3:0]  n_instret;

  mem_wb_stage #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_immediate(mem_immediate),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_funct3(mem_funct3),
    .dmem_rdata(dmem_rdata),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_immediate(wb_immediate),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
    .wb_misaligned(wb_misaligned), .instret(instret)
  );

  mem_wb_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_immediate(mem_immediate),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_funct3(mem_funct3),
    .dmem_rdata(dmem_rdata),
    .wb_alu_result(n_alu_result), .wb_mem_data(n_mem_data),
    .wb_pc_plus_4(n_pc_plus_4), .wb_immediate(n_immediate),
    .wb_mem_to_reg(n_mem_to_reg), .wb_rd(n_rd),
    .wb_reg_write(n_reg_write), .wb_valid(n_valid),
    .wb_misaligned(n_misaligned), .instret(n_instret)
  );

  // ---------------- reference model state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] e_alu, e_mdata, e_pc4, e_imm;
  logic [1:0]  e_sel;
  logic [4:0]  e_rd;
  logic        e_rw, e_valid, e_mis;
  logic [63:0] e_cnt;

  // Load value from the RV32I rules: shift the addressed lane down, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic model_mis(input logic v, input logic [1:0] sel,
                                     input logic [2:0] f3, input logic [1:0] off);
    if (!v || sel != 2'b01) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return (off % 2) != 0;
    if (f3 == 3'b010) return off != 0;
    return 1'b0;
  endfunction

  task automatic model_clear();
    e_alu = 0; e_mdata = 0; e_pc4 = 0; e_imm = 0; e_sel = 0; e_rd = 0;
    e_rw = 0; e_valid = 0; e_mis = 0;
  endtask

  // One rising edge as seen by the model, using the inputs present before it.
  task automatic model_edge();
    logic m;
    if (reset) begin
      model_clear(); e_cnt = 0;
    end else if (flush) begin
      model_clear();
    end else if (!stall) begin
      m       = model_mis(mem_valid, mem_mem_to_reg, mem_funct3, mem_alu_result[1:0]);
      e_alu   = mem_alu_result;
      e_mdata = model_load(dmem_rdata, mem_funct3, mem_alu_result[1:0]);
      e_pc4   = mem_pc_plus_4;
      e_imm   = mem_immediate;
      e_sel   = mem_mem_to_reg;
      e_rd    = mem_rd;
      e_valid = mem_valid;
      e_mis   = m;
      e_rw    = mem_reg_write && mem_valid && (mem_rd != 0) && !m;
      if (mem_valid && !m) e_cnt = e_cnt + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ":alu"},     64'(wb_alu_result), 64'(e_alu));
    chk({where, ":mdata"},   64'(wb_mem_data),   64'(e_mdata));
    chk({where, ":pc4"},     64'(wb_pc_plus_4),  64'(e_pc4));
    chk({where, ":imm"},     64'(wb_immediate),  64'(e_imm));
    chk({where, ":sel"},     64'(wb_mem_to_reg), 64'(e_sel));
    chk({where, ":rd"},      64'(wb_rd),         64'(e_rd));
    chk({where, ":rw"},      64'(wb_reg_write),  64'(e_rw));
    chk({where, ":valid"},   64'(wb_valid),      64'(e_valid));
    chk({where, ":mis"},     64'(wb_misaligned), 64'(e_mis));
    chk({where, ":instret"}, 64'(instret),       e_cnt & 64'hFFFF_FFFF);
    chk({where, ":mdata4"},  64'(n_mem_data),    64'(e_mdata));
    chk({where, ":rw4"},     64'(n_reg_write),   64'(e_rw));
    chk({where, ":instret4"}, 64'(n_instret),    e_cnt & 64'hF);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_random();
    mem_valid      = 1'($urandom_range(0, 1));
    mem_alu_result = $urandom;
    mem_pc_plus_4  = $urandom;
    mem_immediate  = $urandom;
    mem_mem_to_reg = 2'($urandom_range(0, 3));
    mem_rd         = 5'($urandom_range(0, 31));
    mem_reg_write  = 1'($urandom_range(0, 1));
    mem_funct3     = 3'($urandom_range(0, 7));
    dmem_rdata     = $urandom;
  endtask

  task automatic drive_instr(input logic v, input logic [31:0] alu, input logic [1:0] sel,
                             input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                             input logic [31:0] rdata);
    mem_valid = v; mem_alu_result = alu; mem_mem_to_reg = sel; mem_rd = rd;
    mem_reg_write = rw; mem_funct3 = f3; dmem_rdata = rdata;
    mem_pc_plus_4 = $urandom; mem_immediate = $urandom;
  endtask

  // Apply one clock edge, update the model, check on the falling edge.
  task automatic cycle(input string where);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(where);
  endtask

  // ---------------- directed + random sequence ----------------
  typedef struct { logic [2:0] f3; logic [1:0] off; logic [31:0] exp; } load_vec_t;
  load_vec_t loads[5];

  initial begin
    logic [31:0] frozen_alu, frozen_cnt;
    loads[0] = '{3'b000, 2'd3, 32'hFFFF_FF80};
    loads[1] = '{3'b100, 2'd3, 32'h0000_0080};
    loads[2] = '{3'b001, 2'd2, 32'hFFFF_80FF};
    loads[3] = '{3'b101, 2'd0, 32'h0000_7F01};
    loads[4] = '{3'b010, 2'd0, 32'h80FF_7F01};

    // Reset with random inputs driven.
    stall = 0; flush = 0; reset = 1;
    drive_random();
    model_clear(); e_cnt = 0;
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 0;

    // Valid ADD.
    drive_instr(1, 32'h0000_1234, 2'b00, 5'd5, 1, 3'b000, $urandom);
    cycle("add");
    chk("add_rd_const", 64'(wb_rd), 64'd5);
    chk("add_instret_const", 64'(instret), 64'd1);

    // Formatted loads.
    foreach (loads[i]) begin
      drive_instr(1, 32'h0000_0100 | 32'(loads[i].off), 2'b01, 5'd7, 1, loads[i].f3,
                  32'h80FF_7F01);
      cycle("load");
      chk("load_const", 64'(wb_mem_data), 64'(loads[i].exp));
    end

    // Misaligned LW off=2 and LH off=1.
    frozen_cnt = instret;
    drive_instr(1, 32'h0000_0202, 2'b01, 5'd9, 1, 3'b010, 32'h80FF_7F01);
    cycle("mis_lw");
    chk("mis_lw_flag", 64'(wb_misaligned), 64'd1);
    chk("mis_lw_cnt", 64'(instret), 64'(frozen_cnt));
    drive_instr(1, 32'h0000_0301, 2'b01, 5'd9, 1, 3'b001, 32'h80FF_7F01);
    cycle("mis_lh");
    chk("mis_lh_rw", 64'(wb_reg_write), 64'd0);

    // Stall three cycles while inputs change.
    drive_instr(1, 32'hCAFE_0000, 2'b00, 5'd3, 1, 3'b000, $urandom);
    cycle("pre_stall");
    frozen_alu = wb_alu_result; frozen_cnt = instret;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      cycle("stall");
    end
    chk("stall_alu_frozen", 64'(wb_alu_result), 64'(frozen_alu));
    chk("stall_cnt_frozen", 64'(instret), 64'(frozen_cnt));

    // Stall and flush together.
    flush = 1;
    drive_instr(1, 32'h1, 2'b00, 5'd4, 1, 3'b000, $urandom);
    cycle("stall_flush");
    stall = 0; flush = 0;

    // Write to x0, then bubble.
    drive_instr(1, 32'h44, 2'b00, 5'd0, 1, 3'b000, $urandom);
    cycle("x0");
    drive_instr(0, 32'h48, 2'b00, 5'd6, 1, 3'b000, $urandom);
    cycle("bubble");

    // Counter wrap on the 4-bit instance: reset, then 16 retires.
    reset = 1;
    @(negedge clk);
    model_clear(); e_cnt = 0;
    check_all("reset2");
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      drive_instr(1, 32'($urandom) & 32'hFFFF_FFFC, 2'b00, 5'd1, 1, 3'b010, $urandom);
      cycle("wrap");
    end
    chk("wrap4_zero", 64'(n_instret), 64'd0);
    chk("wrap32_sixteen", 64'(instret), 64'd16);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive_random();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    stall = 0; flush = 0;

    // Asynchronous reset between edges.
    drive_instr(1, 32'h55, 2'b11, 5'd8, 1, 3'b000, $urandom);
    cycle("pre_async");
    #2 reset = 1;
    #1;
    model_clear(); e_cnt = 0;
    check_all("async_reset");
    @(negedge clk);
    reset = 0;
    drive_instr(1, 32'h66, 2'b10, 5'd2, 1, 3'b000, $urandom);
    cycle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage for the RV32 core. Registers the memory-stage results and formats raw data-memory read words into RV32I load values.
- Directly feeds the writeback select mux (alu_result, mem_data, pc_plus_4, immediate, mem_to_reg) and supplies the register-file write enable and destination.
- Supports stall and flush, flags misaligned loads, and counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter (allowed range 1..64).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all WB registers and the counter.
- flush  in  1  insert a bubble; has priority over stall.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_alu_result  in  32  ALU result / effective address.
- mem_pc_plus_4  in  32  PC+4 of the MEM instruction.
- mem_immediate  in  32  immediate (LUI path).
- mem_mem_to_reg  in  2  writeback select: 00 ALU, 01 MEM, 10 PC4, 11 IMM.
- mem_rd  in  5  destination register.
- mem_reg_write  in  1  instruction writes rd.
- mem_funct3  in  3  load size/sign code.
- dmem_rdata  in  32  raw aligned word from data memory, valid in the MEM cycle.
- wb_alu_result  out  32  registered alu result.
- wb_mem_data  out  32  registered, formatted load data.
- wb_pc_plus_4  out  32  registered PC+4.
- wb_immediate  out  32  registered immediate.
- wb_mem_to_reg  out  2  registered writeback select.
- wb_rd  out  5  registered destination.
- wb_reg_write  out  1  final register-file write enable.
- wb_valid  out  1  WB holds a real instruction.
- wb_misaligned  out  1  WB holds a misaligned load.
- instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (asynchronous): every output and internal register goes to 0, including instret.
- Latency is one cycle. Values presented in MEM at edge N appear on the wb_* outputs after edge N.
- Per-edge priority: flush > stall > capture.
  - flush: wb_valid=0 and wb_reg_write=0. All other wb_* outputs are cleared to 0.
  - stall (no flush): all registers hold; instret holds.
  - capture: all wb_* outputs load from the mem_* inputs and the formatted load data.
- Load formatting is combinational before the register. off = mem_alu_result[1:0].
  - funct3 000 LB: sign-extend byte at bit offset 8*off.
  - funct3 100 LBU: zero-extend byte at bit offset 8*off.
  - funct3 001 LH: sign-extend halfword selected by off[1] (low half if 0, high half if 1).
  - funct3 101 LHU: zero-extend halfword selected by off[1].
  - funct3 010 LW: the full word.
  - Any other funct3: raw dmem_rdata passes through, never flagged misaligned.
- Misaligned load condition: mem_mem_to_reg==01, mem_valid=1, and either
  - LH/LHU with off[0]=1, or
  - LW with off!=0.
  - Result: wb_misaligned=1 and wb_reg_write forced to 0. wb_mem_data still holds the formatted value, for debug only.
- wb_reg_write is captured as mem_reg_write & mem_valid & (mem_rd!=0) & ~misaligned, so a write to x0 never asserts.
- wb_mem_data is captured regardless of mem_to_reg. The downstream mux ignores it unless the select is 01.
- instret increments by 1 on a capture edge with mem_valid=1 and no misalignment.
  - It wraps from all-ones to 0.
  - No increment on stall, flush, or bubble capture.
- Simultaneous stall and flush: flush wins and the counter does not increment.
- Reset asserted mid-operation clears state immediately, without waiting for the clock edge. On the first edge after reset deasserts, normal capture applies.

Decomposition:
- Shared package riscv_pkg holds:
  - writeback select constants: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10, WB_SEL_IMM=2'b11;
  - load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - XLEN=32.
- One combinational sub-module, load_align, with inputs rdata[31:0], funct3[2:0], off[1:0] and outputs data[31:0], misaligned. The top level adds only the register, the enable/bubble logic and the counter.

Test Plan:
- Reset with random inputs driven: all outputs 0. Then a valid ADD capture (alu_result=0x0000_1234, rd=5, reg_write=1, sel=00) → next cycle wb_alu_result=0x1234, wb_rd=5, wb_reg_write=1, instret=1.
- Loads with dmem_rdata=0x80FF_7F01:
  - LB off=3 → 0xFFFF_FF80
  - LBU off=3 → 0x0000_0080
  - LH off=2 → 0xFFFF_80FF
  - LHU off=0 → 0x0000_7F01
  - LW off=0 → 0x80FF_7F01
- Misaligned: LW off=2 → wb_misaligned=1, wb_reg_write=0, instret unchanged. LH off=1 → same response.
- Stall for 3 cycles while the inputs change → wb_* outputs and instret frozen. Stall+flush on the same edge → wb_valid=0, wb_reg_write=0.
- Write to x0 (rd=0, reg_write=1, valid=1) → wb_reg_write=0, instret increments. Bubble capture (mem_valid=0, reg_write=1) → wb_reg_write=0, instret unchanged.
- CNT_WIDTH=4: retire 16 valid instructions → instret wraps 15→0. Assert reset between clock edges → outputs clear before the next edge.
